sparse_chunk_encoder: RTL

Compresses dense 8-bit activation or filter beats into the sparsemap + nonzero-data write stream consumed by the double-buffered data chunk stores. It is the write side of the chunk interface and sits between the dense feature/weight fetch path and the IFM/filter chunk stores. Per beat it generates the occupancy sparsemap and the lane-packed nonzero bytes. It also sequences beat count and bank select, and holds off input until the selected chunk bank has been released by the reader.

---
 rtl/sparse_chunk_encoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sparse_chunk_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sparse_chunk_encoder
// Function : Turns dense byte beats into a sparsemap plus lane-packed nonzero
//            bytes, and sequences beat index and bank selection for a
//            double-buffered chunk store.
// Revision : 1.0
// ============================================================================
module sparse_chunk_encoder #(
    parameter int BUS_SIZE       = 32,
    parameter int WR_DAT_CYC_NUM = 4,
    parameter int NZ_W           = $clog2(BUS_SIZE*WR_DAT_CYC_NUM)+1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [BUS_SIZE*8-1:0]             in_data_i,
    input  logic                              flush_i,
    input  logic                              rd_release_i,
    input  logic                              rd_release_sel_i,
    output logic                              wr_valid_o,
    output logic [$clog2(WR_DAT_CYC_NUM)-1:0] wr_count_o,
    output logic                              wr_sel_o,
    output logic [BUS_SIZE-1:0]               wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0]             wr_nonzero_data_o,
    output logic                              chunk_done_o,
    output logic [NZ_W-1:0]                   chunk_nz_count_o,
    output logic [1:0]                        bank_busy_o
);

    localparam int CW    = $clog2(WR_DAT_CYC_NUM);
    localparam int CNT_W = $clog2(BUS_SIZE+1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(WR_DAT_CYC_NUM-1);
    localparam logic [CW-1:0] BEAT_ONE  = CW'(1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         beat_q, beat_d;
    logic                  bank_q, bank_d;
    logic [1:0]            busy_q, busy_d;
    logic [NZ_W-1:0]       acc_q, acc_d;

    logic                  wr_valid_q, wr_valid_d;
    logic [CW-1:0]         wr_count_q, wr_count_d;
    logic                  wr_sel_q, wr_sel_d;
    logic [BUS_SIZE-1:0]   map_q, map_d;
    logic [BUS_SIZE*8-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic [NZ_W-1:0]       nz_q, nz_d;

    logic                  w_accept;
    logic                  w_take;
    logic                  w_last;
    logic [BUS_SIZE-1:0]   w_map;
    logic [BUS_SIZE*8-1:0] w_packed;
    logic [CNT_W-1:0]      w_pop;
    logic [NZ_W-1:0]       w_pop_ext;

    generate
        for (genvar g = 0; g < BUS_SIZE; g++) begin : g_lane_map
            assign w_map[g] = |in_data_i[g*8 +: 8];
        end
    endgenerate

    // Compaction: each nonzero byte lands at the next free low lane.
    always_comb begin : p_pack
        int k;
        k        = 0;
        w_packed = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            if (w_map[i]) begin
                w_packed[k*8 +: 8] = in_data_i[i*8 +: 8];
                k = k + 1;
            end
        end
        w_pop = CNT_W'(k);
    end

    assign w_pop_ext = NZ_W'(w_pop);
    assign w_accept  = in_valid_i && in_ready_o;
    assign w_take    = w_accept && !flush_i;
    assign w_last    = (beat_q == LAST_BEAT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (w_take && w_last) begin
                    state_d = busy_d[~bank_q] ? ST_WAIT : ST_FILL;
                end
            end
            ST_WAIT: begin
                if (!busy_q[bank_q]) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_o = 1'b0;
        if (!rst_i && (state_q == ST_FILL)) begin
            in_ready_o = !busy_q[bank_q];
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        beat_d     = beat_q;
        bank_d     = bank_q;
        busy_d     = busy_q;
        acc_d      = acc_q;
        wr_valid_d = w_take;
        wr_count_d = wr_count_q;
        wr_sel_d   = wr_sel_q;
        map_d      = map_q;
        data_d     = data_q;
        done_d     = w_take && w_last;
        nz_d       = nz_q;

        if (rd_release_i) begin
            busy_d[rd_release_sel_i] = 1'b0;
        end

        if (flush_i) begin
            beat_d = '0;
            acc_d  = '0;
        end else if (w_accept) begin
            wr_count_d = beat_q;
            wr_sel_d   = bank_q;
            map_d      = w_map;
            data_d     = w_packed;
            if (w_last) begin
                beat_d         = '0;
                acc_d          = '0;
                bank_d         = ~bank_q;
                // Placed after the release so a same-edge release loses.
                busy_d[bank_q] = 1'b1;
                nz_d           = acc_q + w_pop_ext;
            end else begin
                beat_d = beat_q + BEAT_ONE;
                acc_d  = acc_q + w_pop_ext;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q     <= '0;
            bank_q     <= 1'b0;
            busy_q     <= 2'b00;
            acc_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_count_q <= '0;
            wr_sel_q   <= 1'b0;
            map_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            nz_q       <= '0;
        end else begin
            beat_q     <= beat_d;
            bank_q     <= bank_d;
            busy_q     <= busy_d;
            acc_q      <= acc_d;
            wr_valid_q <= wr_valid_d;
            wr_count_q <= wr_count_d;
            wr_sel_q   <= wr_sel_d;
            map_q      <= map_d;
            data_q     <= data_d;
            done_q     <= done_d;
            nz_q       <= nz_d;
        end
    end

    assign wr_valid_o        = wr_valid_q;
    assign wr_count_o        = wr_count_q;
    assign wr_sel_o          = wr_sel_q;
    assign wr_sparsemap_o    = map_q;
    assign wr_nonzero_data_o = data_q;
    assign chunk_done_o      = done_q;
    assign chunk_nz_count_o  = nz_q;
    assign bank_busy_o       = busy_q;

endmodule
`default_nettype wire
